pulse_cmd_ctrl: RTL and testbench

//  Upstream command stage for the pulse counter (pulse_cmd_ctrl -> pulse counter).
//  - Turns one raw push-button into clean single-cycle start / stop / clr pulses.
//  - Front end: synchronizer, debouncer, press-duration timer, then a control FSM.
//  - Short press toggles run/stop; long press clears the counter; external halt forces stop.
//  - clr drives the counter's synchronous active-high reset; start/stop drive its start/stop inputs.

---
 rtl/pulse_cmd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pulse_cmd_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_ctrl.sv
// pulse_cmd_ctrl: turns one bouncy push-button into clean start/stop/clr
// command pulses for the pulse counter. A short press toggles run/stop, a
// long press clears the counter, and halt forces the stopped state.
module pulse_cmd_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LONG_CYCLES     = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  input  logic halt_i,
  output logic start_o,
  output logic stop_o,
  output logic clr_o,
  output logic running_o
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PRESS_IDLE,
    PRESS_RUN,
    LONG_WAIT
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   db_q;
  logic                   db_d_q;
  logic [DB_W-1:0]        db_cnt_q;
  logic [HOLD_W-1:0]      hold_q;
  logic                   rise;
  logic                   rel;
  logic                   long_hit;

  state_e state_q, state_d;
  logic   start_q, stop_q, clr_q, running_q;
  logic   start_d, stop_d, clr_d, running_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Shift the raw button level through the metastability synchronizer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q     <= 1'b0;
      db_d_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_d_q <= db_q;
      if (btn_s == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_q     <= btn_s;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // Measure how long the debounced button has been held, saturating at the long threshold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (!db_q) begin
      hold_q <= '0;
    end else if (hold_q != HOLD_W'(LONG_CYCLES)) begin
      hold_q <= hold_q + HOLD_W'(1);
    end
  end

  assign rise     = db_q & ~db_d_q;
  assign rel      = db_d_q & ~db_q;
  assign long_hit = db_q & (hold_q == HOLD_W'(LONG_CYCLES - 1));

  // Hold FSM state and the registered command outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      clr_q     <= clr_d;
      running_q <= running_d;
    end
  end

  // Choose the next state; halt outranks any button event in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS_IDLE;
      end
      RUN: begin
        if (halt_i)    state_d = IDLE;
        else if (rise) state_d = PRESS_RUN;
      end
      PRESS_IDLE: begin
        if (rel)           state_d = halt_i ? IDLE : RUN;
        else if (long_hit) state_d = LONG_WAIT;
      end
      PRESS_RUN: begin
        if (halt_i)        state_d = LONG_WAIT;
        else if (rel)      state_d = IDLE;
        else if (long_hit) state_d = LONG_WAIT;
      end
      LONG_WAIT: begin
        if (rel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decide which command pulses fire on this transition
  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_i) stop_d = 1'b1;
      end
      PRESS_IDLE: begin
        if (rel) begin
          start_d = ~halt_i;
        end else if (long_hit) begin
          clr_d = 1'b1;
        end
      end
      PRESS_RUN: begin
        if (halt_i || rel) begin
          stop_d = 1'b1;
        end else if (long_hit) begin
          stop_d = 1'b1;
          clr_d  = 1'b1;
        end
      end
      default: begin
        start_d = 1'b0;
      end
    endcase
    running_d = (state_d == RUN) || (state_d == PRESS_RUN);
  end

  assign start_o   = start_q;
  assign stop_o    = stop_q;
  assign clr_o     = clr_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// Self-checking bench for pulse_cmd_ctrl: directed scenarios followed by
// randomized button/halt traffic, compared against a behavioural model.
module tb_pulse_cmd_ctrl;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LONG = 16;

   logic clk;
   logic rstN;
   logic btnRaw;
   logic halt;
   logic startO, stopO, clrO, runningO;

   int vectors;
   int miscompares;

   // Behavioural model: the raw level seen through a fixed delay, a run-length
   // debouncer, a held-time counter, and the command rules as a run flag plus
   // a press mode (0 no press, 1 press pending, 2 wait for release, no action)
   bit mSyncQ[$];
   bit mDb;
   bit mPrevDb;
   int mDiffRun;
   int mHeld;
   bit mRun;
   int mPressMode;
   bit eStart, eStop, eClr, eRunning;

   int obsStart, obsStop, obsClr, obsBoth;

   pulse_cmd_ctrl #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LONG)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rstN),
      .btn_raw_i(btnRaw),
      .halt_i   (halt),
      .start_o  (startO),
      .stop_o   (stopO),
      .clr_o    (clrO),
      .running_o(runningO)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelReset();
      mSyncQ = {};
      for (int i = 0; i < SYNC; i++) mSyncQ.push_back(1'b0);
      mDb = 0; mPrevDb = 0; mDiffRun = 0; mHeld = 0;
      mRun = 0; mPressMode = 0;
      eStart = 0; eStop = 0; eClr = 0; eRunning = 0;
   endtask

   task automatic modelStep(input bit raw, input bit h);
      bit s, rise, rel, longHit;
      s       = mSyncQ[0];
      rise    = mDb && !mPrevDb;
      rel     = !mDb && mPrevDb;
      longHit = mDb && (mHeld == LONG - 1);
      eStart = 0; eStop = 0; eClr = 0;
      if (mPressMode == 0) begin
         if (mRun && h) begin
            eStop = 1; mRun = 0;
         end else if (rise) begin
            mPressMode = 1;
         end
      end else if (mPressMode == 1) begin
         if (mRun) begin
            if (h) begin
               eStop = 1; mRun = 0; mPressMode = 2;
            end else if (rel) begin
               eStop = 1; mRun = 0; mPressMode = 0;
            end else if (longHit) begin
               eStop = 1; eClr = 1; mRun = 0; mPressMode = 2;
            end
         end else begin
            if (rel) begin
               mPressMode = 0;
               if (!h) begin
                  eStart = 1; mRun = 1;
               end
            end else if (longHit) begin
               eClr = 1; mPressMode = 2;
            end
         end
      end else begin
         if (rel) mPressMode = 0;
      end
      eRunning = mRun;
      // Advance the front end using pre-edge values
      if (mDb) mHeld = (mHeld < LONG) ? mHeld + 1 : LONG;
      else     mHeld = 0;
      mPrevDb = mDb;
      if (s != mDb) begin
         mDiffRun++;
         if (mDiffRun == DEB) begin
            mDb = s;
            mDiffRun = 0;
         end
      end else begin
         mDiffRun = 0;
      end
      mSyncQ.push_back(raw);
      void'(mSyncQ.pop_front());
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic checkCount(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkBit({tag, ".start"}, startO, eStart);
      checkBit({tag, ".stop"}, stopO, eStop);
      checkBit({tag, ".clr"}, clrO, eClr);
      checkBit({tag, ".running"}, runningO, eRunning);
   endtask

   task automatic clearTally();
      obsStart = 0; obsStop = 0; obsClr = 0; obsBoth = 0;
   endtask

   // One clock cycle: drive at the falling edge, check just after the rising edge
   task automatic applyStimulus(input bit raw, input bit h, input string tag);
      btnRaw = raw;
      halt   = h;
      modelStep(raw, h);
      @(posedge clk);
      #1;
      checkOutput(tag);
      obsStart += int'(startO);
      obsStop  += int'(stopO);
      obsClr   += int'(clrO);
      if (stopO && clrO) obsBoth++;
      @(negedge clk);
   endtask

   task automatic holdLevel(input bit raw, input bit h, input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(raw, h, tag);
   endtask

   task automatic shortPress(input bit h, input string tag);
      holdLevel(1'b1, h, 8, tag);
      holdLevel(1'b0, h, 15, tag);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      clearTally();
      modelReset();
      rstN = 1'b0; btnRaw = 1'b0; halt = 1'b0;
      #1;
      checkBit("reset.start", startO, 1'b0);
      checkBit("reset.stop", stopO, 1'b0);
      checkBit("reset.clr", clrO, 1'b0);
      checkBit("reset.running", runningO, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] bounce shorter than debounce window");
      clearTally();
      holdLevel(1'b1, 1'b0, 3, "bounce");
      holdLevel(1'b0, 1'b0, 12, "bounce");
      checkCount("bounce.starts", obsStart, 0);
      checkCount("bounce.stops", obsStop, 0);
      checkBit("bounce.running", runningO, 1'b0);

      $display("[TB] short press twice");
      clearTally();
      shortPress(1'b0, "short1");
      checkCount("short1.starts", obsStart, 1);
      checkBit("short1.running", runningO, 1'b1);
      clearTally();
      shortPress(1'b0, "short2");
      checkCount("short2.stops", obsStop, 1);
      checkCount("short2.starts", obsStart, 0);
      checkBit("short2.running", runningO, 1'b0);

      $display("[TB] long press while running");
      shortPress(1'b0, "torun");
      clearTally();
      holdLevel(1'b1, 1'b0, 30, "longRun");
      holdLevel(1'b0, 1'b0, 15, "longRun");
      checkCount("longRun.stopClr", obsBoth, 1);
      checkCount("longRun.stops", obsStop, 1);
      checkCount("longRun.clrs", obsClr, 1);
      checkCount("longRun.starts", obsStart, 0);
      checkBit("longRun.running", runningO, 1'b0);

      $display("[TB] long press from idle");
      clearTally();
      holdLevel(1'b1, 1'b0, 30, "longIdle");
      holdLevel(1'b0, 1'b0, 15, "longIdle");
      checkCount("longIdle.clrs", obsClr, 1);
      checkCount("longIdle.starts", obsStart, 0);
      checkCount("longIdle.stops", obsStop, 0);
      checkBit("longIdle.running", runningO, 1'b0);

      $display("[TB] halt");
      shortPress(1'b0, "haltRun");
      clearTally();
      applyStimulus(1'b0, 1'b1, "haltPulse");
      holdLevel(1'b0, 1'b0, 3, "haltPulse");
      checkCount("halt.stops", obsStop, 1);
      checkBit("halt.running", runningO, 1'b0);
      clearTally();
      shortPress(1'b1, "haltPress");
      checkCount("haltPress.starts", obsStart, 0);
      checkBit("haltPress.running", runningO, 1'b0);
      halt = 1'b0;

      $display("[TB] async reset mid press");
      shortPress(1'b0, "preReset");
      holdLevel(1'b1, 1'b0, 8, "pressRun");
      checkBit("pressRun.running", runningO, 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      checkBit("asyncReset.start", startO, 1'b0);
      checkBit("asyncReset.stop", stopO, 1'b0);
      checkBit("asyncReset.clr", clrO, 1'b0);
      checkBit("asyncReset.running", runningO, 1'b0);
      modelReset();
      @(negedge clk);
      rstN = 1'b1;
      clearTally();
      holdLevel(1'b1, 1'b0, 2, "postReset");
      holdLevel(1'b0, 1'b0, 15, "postReset");
      checkCount("postReset.pulses", obsStart + obsStop + obsClr, 0);

      $display("[TB] randomized traffic");
      for (int seg = 0; seg < 40; seg++) begin
         bit lvl;
         int len;
         lvl = bit'($urandom_range(0, 1));
         len = int'($urandom_range(1, 25));
         for (int i = 0; i < len; i++) begin
            applyStimulus(lvl, ($urandom_range(0, 19) == 0), "random");
            checkBit("random.exclusive", startO & stopO, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
